// File: rtl/servo_slew_ctrl.sv
// Rate-limited servo duty sequencer: accepts a position command, slews the PWM
// duty word toward it by at most one step per PWM frame, settles, then pulses done.
module servo_slew_ctrl #(
  parameter int DUTY_W    = 9,
  parameter int DUTY_INIT = 256,
  parameter int DUTY_MIN  = 0,
  parameter int DUTY_MAX  = 511,
  parameter int STEP_W    = 4,
  parameter int HOLD_W    = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              frame_tick,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [DUTY_W-1:0] cmd_target,
  input  logic [STEP_W-1:0] cmd_step,
  input  logic [HOLD_W-1:0] cmd_hold,
  input  logic              abort,
  output logic [DUTY_W-1:0] duty,
  output logic              busy,
  output logic              done
);

  localparam logic [DUTY_W-1:0] INIT_V = DUTY_W'(DUTY_INIT);
  localparam logic [DUTY_W-1:0] MIN_V  = DUTY_W'(DUTY_MIN);
  localparam logic [DUTY_W-1:0] MAX_V  = DUTY_W'(DUTY_MAX);

  typedef enum logic [1:0] {IDLE, RAMP, SETTLE} state_t;

  state_t              state_q, state_d;
  logic [DUTY_W-1:0]   duty_q, duty_d;
  logic [DUTY_W-1:0]   target_q, target_d;
  logic [STEP_W-1:0]   step_q, step_d;
  logic [HOLD_W-1:0]   hold_cfg_q, hold_cfg_d;
  logic [HOLD_W-1:0]   hold_q, hold_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;

  logic [DUTY_W-1:0]   tgt_lo;
  logic [DUTY_W-1:0]   tgt_clamped;
  logic signed [DUTY_W:0] diff;
  logic [DUTY_W:0]     abs_diff;
  logic [DUTY_W:0]     step_ext;

  // Clamp comparisons only exist when the legal range is narrower than the word.
  generate
    if (DUTY_MIN > 0) begin : g_min_clamp
      assign tgt_lo = (cmd_target < MIN_V) ? MIN_V : cmd_target;
    end else begin : g_no_min_clamp
      assign tgt_lo = cmd_target;
    end
    if (DUTY_MAX < (2 ** DUTY_W) - 1) begin : g_max_clamp
      assign tgt_clamped = (tgt_lo > MAX_V) ? MAX_V : tgt_lo;
    end else begin : g_no_max_clamp
      assign tgt_clamped = tgt_lo;
    end
  endgenerate

  assign diff     = $signed({1'b0, target_q}) - $signed({1'b0, duty_q});
  assign abs_diff = diff[DUTY_W] ? -diff : diff;
  assign step_ext = (DUTY_W+1)'(step_q);

  assign cmd_ready = (state_q == IDLE) & ~abort;
  assign duty      = duty_q;
  assign busy      = busy_q;
  assign done      = done_q;

  always_comb begin
    state_d    = state_q;
    duty_d     = duty_q;
    target_d   = target_q;
    step_d     = step_q;
    hold_cfg_d = hold_cfg_q;
    hold_d     = hold_q;
    done_d     = 1'b0;

    // Abort outranks both a frame tick and a pending command.
    if (abort) begin
      state_d = IDLE;
      hold_d  = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (cmd_valid) begin
            target_d   = tgt_clamped;
            step_d     = (cmd_step == '0) ? STEP_W'(1) : cmd_step;
            hold_cfg_d = cmd_hold;
            state_d    = RAMP;
          end
        end
        RAMP: begin
          if (frame_tick) begin
            if (abs_diff <= step_ext) begin
              duty_d  = target_q;
              hold_d  = hold_cfg_q;
              state_d = SETTLE;
            end else if (diff > 0) begin
              duty_d = duty_q + DUTY_W'(step_q);
            end else begin
              duty_d = duty_q - DUTY_W'(step_q);
            end
          end
        end
        SETTLE: begin
          if (hold_q == '0) begin
            done_d  = 1'b1;
            state_d = IDLE;
          end else if (frame_tick) begin
            hold_d = hold_q - 1'b1;
            if (hold_q == HOLD_W'(1)) begin
              done_d  = 1'b1;
              state_d = IDLE;
            end
          end
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      duty_q     <= INIT_V;
      target_q   <= INIT_V;
      step_q     <= STEP_W'(1);
      hold_cfg_q <= '0;
      hold_q     <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      duty_q     <= duty_d;
      target_q   <= target_d;
      step_q     <= step_d;
      hold_cfg_q <= hold_cfg_d;
      hold_q     <= hold_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

endmodule

// File: tb/tb_servo_slew_ctrl.sv
// Self-checking bench for servo_slew_ctrl: directed scenarios plus a randomized
// run compared against a frame-level motion model.
module tb_servo_slew_ctrl;

  localparam int DW     = 9;
  localparam int SW     = 4;
  localparam int HW     = 8;
  localparam int D_INIT = 256;
  localparam int D_MIN  = 0;
  localparam int D_MAX  = 480;

  logic          clk = 1'b0;
  logic          rst;
  logic          frame_tick, cmd_valid, cmd_ready, abort, busy, done;
  logic [DW-1:0] cmd_target, duty;
  logic [SW-1:0] cmd_step;
  logic [HW-1:0] cmd_hold;

  int n_vec = 0;
  int n_bad = 0;

  // Model: 0 = waiting for command, 1 = moving, 2 = settling.
  int m_duty, m_target, m_step, m_hold_cfg, m_hold_left, m_mode, m_done;

  servo_slew_ctrl #(
    .DUTY_W(DW), .DUTY_INIT(D_INIT), .DUTY_MIN(D_MIN), .DUTY_MAX(D_MAX),
    .STEP_W(SW), .HOLD_W(HW)
  ) dut (
    .clk(clk), .rst(rst), .frame_tick(frame_tick), .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready), .cmd_target(cmd_target), .cmd_step(cmd_step),
    .cmd_hold(cmd_hold), .abort(abort), .duty(duty), .busy(busy), .done(done)
  );

  always #100 clk = ~clk;

  initial begin
    #(200 * 20000);
    $display("[TB] FAIL watchdog expired at %0t, required finish before it", $time);
    $fatal(1, "[TB] watchdog");
  end

  function automatic int clamp(input int v);
    return (v < D_MIN) ? D_MIN : (v > D_MAX) ? D_MAX : v;
  endfunction

  function automatic void model_reset();
    m_duty = D_INIT; m_target = D_INIT; m_step = 1;
    m_hold_cfg = 0; m_hold_left = 0; m_mode = 0; m_done = 0;
  endfunction

  // One clock of the motion rules, using the inputs sampled at that edge.
  function automatic void model_edge();
    int d, mag;
    m_done = 0;
    if (abort) begin
      m_mode = 0;
      m_hold_left = 0;
    end else if (m_mode == 0) begin
      if (cmd_valid) begin
        m_target   = clamp(int'(cmd_target));
        m_step     = (cmd_step == 0) ? 1 : int'(cmd_step);
        m_hold_cfg = int'(cmd_hold);
        m_mode     = 1;
      end
    end else if (m_mode == 1) begin
      if (frame_tick) begin
        d   = m_target - m_duty;
        mag = (d < 0) ? -d : d;
        if (mag <= m_step) begin
          m_duty = m_target;
          m_hold_left = m_hold_cfg;
          m_mode = 2;
        end else begin
          m_duty = m_duty + ((d > 0) ? m_step : -m_step);
        end
      end
    end else begin
      if (m_hold_left == 0) begin
        m_done = 1; m_mode = 0;
      end else if (frame_tick) begin
        m_hold_left--;
        if (m_hold_left == 0) begin
          m_done = 1; m_mode = 0;
        end
      end
    end
  endfunction

  task automatic step_edge();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic drive(input bit t, input bit v, input bit a);
    frame_tick = t; cmd_valid = v; abort = a;
    step_edge();
  endtask

  task automatic set_cmd(input int tgt, input int stp, input int hld);
    cmd_target = DW'(tgt); cmd_step = SW'(stp); cmd_hold = HW'(hld);
  endtask

  task automatic run_to_done(input int budget, output bit seen);
    seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      drive(1'b1, 1'b0, 1'b0);
      if (done) seen = 1'b1;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; frame_tick = 0; cmd_valid = 0; abort = 0; set_cmd(0, 0, 0);
    #5 rst = 1'b0;
    model_reset();
    #20;
    n_vec++;
    if ({duty, busy, done, cmd_ready} !== {9'd256, 1'b0, 1'b0, 1'b1}) begin
      n_bad++;
      $display("[TB] FAIL reset_values duty=%0d busy=%b done=%b ready=%b required 256/0/0/1",
               duty, busy, done, cmd_ready);
    end
    @(negedge clk) rst = 1'b1;
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 1'b0, 1'b0);
      drive(1'b0, 1'b0, 1'b0);
      n_vec++;
      if ({duty, busy, done, cmd_ready} !== {9'd256, 1'b0, 1'b0, 1'b1}) begin
        n_bad++;
        $display("[TB] FAIL reset_idle_tick%0d duty=%0d busy=%b done=%b ready=%b required 256/0/0/1",
                 i, duty, busy, done, cmd_ready);
      end
    end
  endtask

  task automatic test_ramp_up();
    int exp_up[5] = '{266, 276, 286, 296, 300};
    set_cmd(300, 10, 2);
    drive(1'b0, 1'b1, 1'b0);
    n_vec++;
    if ({busy, duty} !== {1'b1, 9'd256}) begin
      n_bad++;
      $display("[TB] FAIL up_accept busy=%b duty=%0d required 1/256", busy, duty);
    end
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 1'b0, 1'b0);
      n_vec++;
      if (duty !== DW'(exp_up[i])) begin
        n_bad++;
        $display("[TB] FAIL up_tick%0d duty=%0d required %0d", i + 1, duty, exp_up[i]);
      end
      drive(1'b0, 1'b0, 1'b0);
      n_vec++;
      if (duty !== DW'(exp_up[i])) begin
        n_bad++;
        $display("[TB] FAIL up_between%0d duty=%0d required %0d", i + 1, duty, exp_up[i]);
      end
    end
    drive(1'b1, 1'b0, 1'b0);
    n_vec++;
    if ({busy, done} !== 2'b10) begin
      n_bad++;
      $display("[TB] FAIL up_settle6 busy=%b done=%b required 1/0", busy, done);
    end
    drive(1'b1, 1'b0, 1'b0);
    n_vec++;
    if ({done, duty} !== {1'b1, 9'd300}) begin
      n_bad++;
      $display("[TB] FAIL up_done7 done=%b duty=%0d required 1/300", done, duty);
    end
    drive(1'b0, 1'b0, 1'b0);
    n_vec++;
    if ({busy, done, cmd_ready} !== 3'b001) begin
      n_bad++;
      $display("[TB] FAIL up_after busy=%b done=%b ready=%b required 0/0/1", busy, done, cmd_ready);
    end
  endtask

  task automatic test_clamp_zero_step();
    bit seen;
    set_cmd(478, 15, 0);
    drive(1'b0, 1'b1, 1'b0);
    run_to_done(40, seen);
    n_vec++;
    if (!seen || duty !== 9'd478) begin
      n_bad++;
      $display("[TB] FAIL clamp_setup done_seen=%b duty=%0d required 1/478", seen, duty);
    end
    drive(1'b0, 1'b0, 1'b0);
    set_cmd(511, 0, 0);
    drive(1'b0, 1'b1, 1'b0);
    drive(1'b1, 1'b0, 1'b0);
    n_vec++;
    if (duty !== 9'd479) begin
      n_bad++;
      $display("[TB] FAIL clamp_tick1 duty=%0d required 479", duty);
    end
    drive(1'b1, 1'b0, 1'b0);
    n_vec++;
    if ({duty, busy, done} !== {9'd480, 1'b1, 1'b0}) begin
      n_bad++;
      $display("[TB] FAIL clamp_arrive duty=%0d busy=%b done=%b required 480/1/0", duty, busy, done);
    end
    drive(1'b0, 1'b0, 1'b0);
    n_vec++;
    if ({duty, busy, done} !== {9'd480, 1'b0, 1'b1}) begin
      n_bad++;
      $display("[TB] FAIL clamp_done duty=%0d busy=%b done=%b required 480/0/1", duty, busy, done);
    end
  endtask

  task automatic test_ramp_down();
    int exp_dn[7] = '{85, 70, 55, 40, 25, 10, 5};
    bit seen;
    set_cmd(100, 15, 0);
    drive(1'b0, 1'b1, 1'b0);
    run_to_done(60, seen);
    drive(1'b0, 1'b0, 1'b0);
    n_vec++;
    if (!seen || duty !== 9'd100) begin
      n_bad++;
      $display("[TB] FAIL down_setup done_seen=%b duty=%0d required 1/100", seen, duty);
    end
    set_cmd(5, 15, 0);
    drive(1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 7; i++) begin
      drive(1'b1, 1'b0, 1'b0);
      n_vec++;
      if (duty !== DW'(exp_dn[i]) || done !== 1'b0) begin
        n_bad++;
        $display("[TB] FAIL down_tick%0d duty=%0d done=%b required %0d/0", i + 1, duty, done, exp_dn[i]);
      end
    end
    drive(1'b0, 1'b0, 1'b0);
    n_vec++;
    if ({duty, done} !== {9'd5, 1'b1}) begin
      n_bad++;
      $display("[TB] FAIL down_done duty=%0d done=%b required 5/1", duty, done);
    end
  endtask

  task automatic test_abort();
    bit seen;
    set_cmd(256, 15, 0);
    drive(1'b0, 1'b1, 1'b0);
    run_to_done(60, seen);
    drive(1'b0, 1'b0, 1'b0);
    set_cmd(300, 10, 0);
    drive(1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) drive(1'b1, 1'b0, 1'b0);
    n_vec++;
    if (!seen || duty !== 9'd286) begin
      n_bad++;
      $display("[TB] FAIL abort_setup done_seen=%b duty=%0d required 1/286", seen, duty);
    end
    drive(1'b1, 1'b0, 1'b1);
    n_vec++;
    if ({duty, busy, done, cmd_ready} !== {9'd286, 1'b0, 1'b0, 1'b0}) begin
      n_bad++;
      $display("[TB] FAIL abort_hold duty=%0d busy=%b done=%b ready=%b required 286/0/0/0",
               duty, busy, done, cmd_ready);
    end
    abort = 1'b0;
    #1;
    n_vec++;
    if (cmd_ready !== 1'b1) begin
      n_bad++;
      $display("[TB] FAIL abort_ready ready=%b required 1", cmd_ready);
    end
    set_cmd(250, 50, 0);
    drive(1'b0, 1'b1, 1'b0);
    n_vec++;
    if (busy !== 1'b1) begin
      n_bad++;
      $display("[TB] FAIL abort_reaccept busy=%b required 1", busy);
    end
    run_to_done(20, seen);
    n_vec++;
    if (!seen || duty !== 9'd250) begin
      n_bad++;
      $display("[TB] FAIL abort_next_done done_seen=%b duty=%0d required 1/250", seen, duty);
    end
    drive(1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_corners();
    set_cmd(400, 5, 0);
    drive(1'b0, 1'b1, 1'b0);
    drive(1'b1, 1'b0, 1'b0);
    #30 rst = 1'b0;
    #5;
    model_reset();
    n_vec++;
    if ({duty, busy, done} !== {9'd256, 1'b0, 1'b0}) begin
      n_bad++;
      $display("[TB] FAIL mid_reset duty=%0d busy=%b done=%b required 256/0/0", duty, busy, done);
    end
    @(negedge clk) rst = 1'b1;

    set_cmd(300, 8, 0);
    drive(1'b1, 1'b1, 1'b0);
    n_vec++;
    if ({duty, busy} !== {9'd256, 1'b1}) begin
      n_bad++;
      $display("[TB] FAIL accept_with_tick duty=%0d busy=%b required 256/1", duty, busy);
    end
    drive(1'b1, 1'b0, 1'b0);
    n_vec++;
    if (duty !== 9'd264) begin
      n_bad++;
      $display("[TB] FAIL first_tick_after_accept duty=%0d required 264", duty);
    end
    drive(1'b0, 1'b0, 1'b1);

    set_cmd(264, 3, 1);
    drive(1'b0, 1'b1, 1'b0);
    drive(1'b1, 1'b0, 1'b0);
    n_vec++;
    if ({duty, busy, done} !== {9'd264, 1'b1, 1'b0}) begin
      n_bad++;
      $display("[TB] FAIL equal_settle duty=%0d busy=%b done=%b required 264/1/0", duty, busy, done);
    end
    drive(1'b0, 1'b0, 1'b0);
    drive(1'b1, 1'b0, 1'b0);
    n_vec++;
    if ({duty, done} !== {9'd264, 1'b1}) begin
      n_bad++;
      $display("[TB] FAIL equal_done duty=%0d done=%b required 264/1", duty, done);
    end
  endtask

  task automatic test_random();
    bit t, a, v, acc;
    cmd_valid = 1'b0;
    for (int i = 0; i < 600; i++) begin
      if (!cmd_valid) set_cmd(int'($urandom_range(0, 511)), int'($urandom_range(0, 15)),
                              int'($urandom_range(0, 3)));
      t = ($urandom_range(0, 3) == 0);
      a = ($urandom_range(0, 29) == 0);
      v = cmd_valid ? 1'b1 : ($urandom_range(0, 2) == 0);
      frame_tick = t; abort = a; cmd_valid = v;
      #1;
      n_vec++;
      if (cmd_ready !== (m_mode == 0 && !a)) begin
        n_bad++;
        $display("[TB] FAIL rand_ready%0d ready=%b required %b", i, cmd_ready, (m_mode == 0 && !a));
      end
      acc = v && (m_mode == 0) && !a;
      step_edge();
      n_vec++;
      if (duty !== DW'(m_duty) || busy !== (m_mode != 0) || done !== m_done[0]) begin
        n_bad++;
        $display("[TB] FAIL rand_cycle%0d duty=%0d busy=%b done=%b required %0d/%b/%b",
                 i, duty, busy, done, m_duty, (m_mode != 0), m_done[0]);
      end
      if (acc) cmd_valid = 1'b0;
    end
  endtask

  initial begin
    test_reset();
    test_ramp_up();
    test_clamp_zero_step();
    test_ramp_down();
    test_abort();
    test_corners();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
